// File: rtl/cnn_mul_arb_14s_6s.sv
// Round-robin arbiter that lets N_REQ requesters share one pipelined signed
// 14x6 multiplier. Results come out in acceptance order, tagged with the
// index of the requester that issued them.
module cnn_mul_arb_14s_6s #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic                                  ap_clk,
  input  logic                                  ap_rst_n,
  input  logic [N_REQ-1:0]                      req_valid,
  output logic [N_REQ-1:0]                      req_ready,
  input  logic [14*N_REQ-1:0]                   req_a,
  input  logic [6*N_REQ-1:0]                    req_b,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [$clog2(N_REQ)-1:0]              res_id,
  output logic signed [19:0]                    res_p,
  output logic [$clog2(MUL_STAGES+1):0]         inflight,
  output logic                                  idle
);

  localparam int unsigned A_W   = 14;
  localparam int unsigned B_W   = 6;
  localparam int unsigned P_W   = 20;
  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MUL_STAGES + 1) + 1;

  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         gnt;
  logic [ID_W-1:0]         idx;
  logic                    gnt_found;
  logic                    adv;
  logic                    in_hs;
  logic                    out_hs;
  logic signed [A_W-1:0]   a_sel;
  logic signed [B_W-1:0]   b_sel;
  logic signed [P_W-1:0]   prod;
  logic [CNT_W-1:0]        inflight_nxt;

  logic [MUL_STAGES-1:0]   st_valid;
  logic [ID_W-1:0]         st_id [MUL_STAGES];
  logic signed [P_W-1:0]   st_p  [MUL_STAGES];

  assign res_valid = st_valid[MUL_STAGES-1];
  assign res_id    = st_id[MUL_STAGES-1];
  assign res_p     = st_p[MUL_STAGES-1];
  assign adv       = !res_valid || res_ready;
  assign out_hs    = res_valid && res_ready;
  assign in_hs     = adv && gnt_found;

  // Round-robin search starting at rr_ptr; N_REQ is a power of two so the
  // index wraps naturally in ID_W bits.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = rr_ptr + ID_W'(k);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
      end
    end
  end

  // One-hot accept to the granted requester while the pipeline can advance.
  always_comb begin
    req_ready = '0;
    if (adv && gnt_found) req_ready[gnt] = 1'b1;
  end

  // Operand select and full-width signed product captured into stage 1.
  always_comb begin
    a_sel = req_a[A_W*gnt +: A_W];
    b_sel = req_b[B_W*gnt +: B_W];
    prod  = P_W'(a_sel) * P_W'(b_sel);
  end

  // Occupancy update: both handshakes in one cycle leave the count unchanged.
  always_comb begin
    inflight_nxt = inflight;
    case ({in_hs, out_hs})
      2'b10:   inflight_nxt = inflight + CNT_W'(1);
      2'b01:   inflight_nxt = inflight - CNT_W'(1);
      default: inflight_nxt = inflight;
    endcase
  end

  // Arbitration pointer and occupancy bookkeeping.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr   <= '0;
      inflight <= '0;
      idle     <= 1'b1;
    end else begin
      if (in_hs) rr_ptr <= gnt + ID_W'(1);
      inflight <= inflight_nxt;
      idle     <= (inflight_nxt == '0);
    end
  end

  // Multiplier pipeline; every stage holds while the output is stalled.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      st_valid <= '0;
      for (int unsigned s = 0; s < MUL_STAGES; s++) begin
        st_id[s] <= '0;
        st_p[s]  <= '0;
      end
    end else if (adv) begin
      st_valid[0] <= in_hs;
      st_id[0]    <= gnt;
      st_p[0]     <= prod;
      for (int unsigned s = 1; s < MUL_STAGES; s++) begin
        st_valid[s] <= st_valid[s-1];
        st_id[s]    <= st_id[s-1];
        st_p[s]     <= st_p[s-1];
      end
    end
  end

endmodule

// File: tb/tb_cnn_mul_arb_14s_6s.sv
// Directed self-checking bench for cnn_mul_arb_14s_6s (N_REQ=4, MUL_STAGES=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cnn_mul_arb_14s_6s;

  logic               ap_clk;
  logic               ap_rst_n;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [55:0]        req_a;
  logic [23:0]        req_b;
  logic               res_valid;
  logic               res_ready;
  logic [1:0]         res_id;
  logic signed [19:0] res_p;
  logic [2:0]         inflight;
  logic               idle;

  int checks = 0;
  int errors = 0;

  cnn_mul_arb_14s_6s #(.N_REQ(4), .MUL_STAGES(2)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p),
    .inflight  (inflight),
    .idle      (idle)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic set_op(input int i, input logic signed [13:0] a, input logic signed [5:0] b);
    req_a[14*i +: 14] = a;
    req_b[6*i +: 6]   = b;
  endtask

  task automatic apply_reset();
    @(negedge ap_clk);
    ap_rst_n  = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++;
    if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    checks++;
    if (res_p !== 20'sd0 || res_id !== 2'd0) begin
      errors++; $display("FAIL reset_res got p=%0d id=%0d want 0/0", res_p, res_id);
    end
  endtask

  // Single operation from requester 0; checks latency, product and inflight 1,1,0.
  task automatic test_single(input logic signed [13:0] a, input logic signed [5:0] b,
                             input logic signed [19:0] exp_p, input string name);
    apply_reset();
    set_op(0, a, b);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL %s_ready got %b want 0001", name, req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    checks++;
    if (inflight !== 3'd1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL %s_c1 got inflight=%0d res_valid=%b want 1/0", name, inflight, res_valid);
    end
    @(negedge ap_clk);
    checks++;
    if (res_valid !== 1'b1 || res_p !== exp_p || res_id !== 2'd0 || inflight !== 3'd1) begin
      errors++;
      $display("FAIL %s_result got v=%b p=%0d id=%0d inflight=%0d want 1/%0d/0/1",
               name, res_valid, res_p, res_id, inflight, exp_p);
    end
    @(negedge ap_clk);
    checks++;
    if (res_valid !== 1'b0 || inflight !== 3'd0 || idle !== 1'b1) begin
      errors++; $display("FAIL %s_c3 got v=%b inflight=%0d idle=%b want 0/0/1", name, res_valid, inflight, idle);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]         exp_g [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic signed [19:0] exp_p [4] = '{-20'sd5000, -20'sd12000, -20'sd21000, -20'sd32000};
    logic [3:0] oh;
    apply_reset();
    set_op(0, 14'sd1000, -6'sd5);
    set_op(1, 14'sd2000, -6'sd6);
    set_op(2, 14'sd3000, -6'sd7);
    set_op(3, 14'sd4000, -6'sd8);
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 6) begin
        oh = 4'b0001 << exp_g[c];
        checks++;
        if (req_ready !== oh) begin errors++; $display("FAIL rr_grant c=%0d got %b want %b", c, req_ready, oh); end
      end
      if (c >= 2 && c < 8) begin
        checks++;
        if (res_valid !== 1'b1 || res_id !== exp_g[c-2] || res_p !== exp_p[exp_g[c-2]]) begin
          errors++;
          $display("FAIL rr_result c=%0d got v=%b id=%0d p=%0d want 1/%0d/%0d",
                   c, res_valid, res_id, res_p, exp_g[c-2], exp_p[exp_g[c-2]]);
        end
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if (inflight !== 3'd2) begin errors++; $display("FAIL rr_inflight c=%0d got %0d want 2", c, inflight); end
      end
      if (c == 8) begin
        checks++;
        if (res_valid !== 1'b0 || inflight !== 3'd0) begin
          errors++; $display("FAIL rr_drain got v=%b inflight=%0d want 0/0", res_valid, inflight);
        end
      end
      @(negedge ap_clk);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] exp_r;
    apply_reset();
    set_op(1, 14'sd5, 6'sd3);
    set_op(3, -14'sd7, 6'sd2);
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 4'b1010 : 4'b0000;
      #1;
      if (c < 4) begin
        exp_r = (c % 2 == 0) ? 4'b0010 : 4'b1000;
        checks++;
        if (req_ready !== exp_r) begin errors++; $display("FAIL alt_grant c=%0d got %b want %b", c, req_ready, exp_r); end
      end
      if (c >= 2) begin
        checks++;
        if (c % 2 == 0) begin
          if (res_valid !== 1'b1 || res_id !== 2'd1 || res_p !== 20'sd15) begin
            errors++; $display("FAIL alt_result c=%0d got v=%b id=%0d p=%0d want 1/1/15", c, res_valid, res_id, res_p);
          end
        end else begin
          if (res_valid !== 1'b1 || res_id !== 2'd3 || res_p !== -20'sd14) begin
            errors++; $display("FAIL alt_result c=%0d got v=%b id=%0d p=%0d want 1/3/-14", c, res_valid, res_id, res_p);
          end
        end
      end
      @(negedge ap_clk);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_op(0, 14'sd10, 6'sd10);
    req_valid = 4'b0001;
    @(negedge ap_clk);
    set_op(0, -14'sd3, 6'sd5);
    @(negedge ap_clk);
    // Two ops in flight; stall the output for three cycles with req2 waiting.
    set_op(2, 14'sd1, 6'sd1);
    req_valid = 4'b0100;
    res_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_p !== 20'sd100 || res_id !== 2'd0 ||
          req_ready !== 4'b0000 || inflight !== 3'd2) begin
        errors++;
        $display("FAIL stall c=%0d got v=%b p=%0d id=%0d ready=%b inflight=%0d want 1/100/0/0000/2",
                 c, res_valid, res_p, res_id, req_ready, inflight);
      end
      @(negedge ap_clk);
    end
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b1 || res_p !== 20'sd100) begin
      errors++; $display("FAIL release_first got v=%b p=%0d want 1/100", res_valid, res_p);
    end
    @(negedge ap_clk);
    checks++;
    if (res_valid !== 1'b1 || res_p !== -20'sd15 || res_id !== 2'd0 || inflight !== 3'd1) begin
      errors++; $display("FAIL release_second got v=%b p=%0d id=%0d inflight=%0d want 1/-15/0/1",
                         res_valid, res_p, res_id, inflight);
    end
    @(negedge ap_clk);
    checks++;
    if (res_valid !== 1'b0 || inflight !== 3'd0) begin
      errors++; $display("FAIL release_drain got v=%b inflight=%0d want 0/0", res_valid, inflight);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_op(0, 14'sd100, 6'sd2);
    req_valid = 4'b0001;
    @(negedge ap_clk);
    @(negedge ap_clk);
    req_valid = '0;
    res_ready = 1'b0;
    #1;
    checks++;
    if (inflight !== 3'd2 || res_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got inflight=%0d v=%b want 2/1", inflight, res_valid);
    end
    #1 ap_rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || inflight !== 3'd0 || idle !== 1'b1) begin
      errors++; $display("FAIL mid_async got v=%b inflight=%0d idle=%b want 0/0/1", res_valid, inflight, idle);
    end
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
    res_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      checks++;
      if (res_valid !== 1'b0 || inflight !== 3'd0) begin
        errors++; $display("FAIL mid_stale c=%0d got v=%b inflight=%0d want 0/0", c, res_valid, inflight);
      end
    end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b want 0001", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    test_reset();
    test_single(-14'sd8192, -6'sd32, 20'sd262144, "mul_neg_neg");
    test_single(14'sd8191, -6'sd32, -20'sd262112, "mul_pos_neg");
    test_round_robin();
    test_alternate();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_mul_arb_14s_6s.md
CNN_MUL_ARB_14S_6S -- requirements
Module: cnn_mul_arb_14s_6s

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing one signed multiplier (power of two, 2..8).
REQ-002 Parameter MUL_STAGES, 2, register stages from operand capture to res_p (1..4).
REQ-003 ap_clk  in  1  single clock; all state changes on rising edge.
REQ-004 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  N_REQ  per-requester operand valid.
REQ-006 req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  in  14*N_REQ  signed 14-bit operand A; slice i at bits [14i+13:14i].
REQ-008 req_b  in  6*N_REQ  signed 6-bit operand B; slice i at bits [6i+5:6i].
REQ-009 res_valid  out  1  result valid.
REQ-010 res_ready  in  1  downstream accept.
REQ-011 res_id  out  log2(N_REQ)  index of the requester that issued res_p.
REQ-012 res_p  out  20  signed product.
REQ-013 inflight  out  log2(MUL_STAGES+1)+1  count of accepted but not yet delivered operations.
REQ-014 idle  out  1  high when inflight == 0.

Function
REQ-015 adv = !res_valid || res_ready; the pipeline advances only when adv = 1.
REQ-016 Grant: the first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
REQ-017 req_ready[g] = adv and a grant g exists; all other req_ready bits 0; req_ready is combinational and does not depend on req_valid[g] beyond grant selection.
REQ-018 Handshake on requester g = req_valid[g] && req_ready[g]; on handshake rr_ptr <= (g+1) mod N_REQ, otherwise rr_ptr holds.
REQ-019 On adv, stage 1 captures the granted slices of req_a/req_b, g, and valid = handshake; with no grant, stage 1 captures a bubble (valid 0).
REQ-020 On adv, every later stage takes the previous stage; when adv = 0, all stages and the output hold.
REQ-021 Latency: handshake in cycle t gives res_valid = 1 with the matching res_p/res_id in cycle t+MUL_STAGES, provided adv stays 1.
REQ-022 Throughput: one operation per cycle while res_ready = 1.
REQ-023 Arithmetic: res_p = signed(a) * signed(b), exact full-width 20-bit result with no truncation or saturation.
REQ-024 Results are delivered in acceptance order; bubbles are not collapsed.
REQ-025 While res_valid && !res_ready, res_p and res_id stay stable and all req_ready bits are 0.
REQ-026 inflight increments on an input handshake, decrements on an output handshake (res_valid && res_ready), and is unchanged when both occur in the same cycle.
REQ-027 inflight never exceeds MUL_STAGES.
REQ-028 A requester whose req_valid drops without a handshake loses nothing and does not move rr_ptr.

Reset
REQ-029 ap_rst_n low immediately clears all stage valids, res_valid, res_p, res_id, rr_ptr and inflight to 0, and sets idle to 1.
REQ-030 An asynchronous reset mid-operation discards all in-flight operations; no stale result is presented after reset release.
REQ-031 The first grant after reset release follows the search order from requester 0.

Verification
REQ-032 Req0 only, a=-8192, b=-32, res_ready=1: handshake in cycle 0 -> res_valid in cycle 2 with res_p=262144 and res_id=0; inflight sequence 1,1,0.
REQ-033 Req0 only, a=8191, b=-32 -> res_p=-262112 (0xC0020).
REQ-034 All four requesters held valid, res_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; results in that id order, one per cycle.
REQ-035 Only req1 and req3 held valid -> grants alternate 1,3,1,3; req0 and req2 never granted.
REQ-036 Result pending with res_ready=0 for 3 cycles -> res_p/res_id constant, req_ready=0, inflight constant; after release, all results are delivered with none lost or duplicated.
REQ-037 Two operations in flight, ap_rst_n pulsed low mid-cycle -> res_valid=0 and inflight=0 without waiting for a clock edge, idle=1, and no result appears afterwards.
